// File: rtl/btc_miner_pkg.sv
// Shared constants for the multi-core miner register block: address map,
// CONTROL/STATUS bit positions and the per-core nonce partitioning helper.
package btc_miner_pkg;

  localparam int HEADER_WORDS  = 20;
  localparam int NONCE_IN_WORD = 19;
  localparam int ENTRY_W       = 35;

  localparam logic [7:0] ADDR_CONFIG       = 8'h00;
  localparam logic [7:0] ADDR_HDR_FIRST    = 8'h04;
  localparam logic [7:0] ADDR_HDR_LAST     = 8'h50;
  localparam logic [7:0] ADDR_CONTROL      = 8'h54;
  localparam logic [7:0] ADDR_STATUS       = 8'h58;
  localparam logic [7:0] ADDR_RESULT_NONCE = 8'h5C;
  localparam logic [7:0] ADDR_RESULT_INFO  = 8'h60;
  localparam logic [7:0] ADDR_IRQ_EN       = 8'h64;

  localparam int CTRL_START_BIT   = 0;
  localparam int CTRL_CLR_OVF_BIT = 1;
  localparam int CTRL_FLUSH_BIT   = 2;

  localparam int STAT_EMPTY_BIT = 16;
  localparam int STAT_OVF_BIT   = 17;
  localparam int STAT_IRQ_BIT   = 18;

  // Core idx searches its own 1/ncores slice of the 32-bit nonce space.
  function automatic logic [31:0] nonce_offset(input int idx, input int ncores);
    logic [32:0] step;
    step = 33'h1_0000_0000 / 33'(ncores);
    return 32'(step * 33'(idx));
  endfunction

endpackage

// File: rtl/btc_result_fifo.sv
// Result FIFO for {core, nonce} entries; pointers carry an extra wrap bit so
// full and empty are distinguishable without a separate counter.
module btc_result_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [WIDTH-1:0]           head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  // A pop frees the head slot in the same cycle, so a full FIFO can still accept.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

endmodule

// File: rtl/btc_miner_regs_mc.sv
// Wishbone register block for a multi-core miner: header broadcast, per-core
// start/nonce partitioning, result synchronisation, arbitration and result FIFO.
module btc_miner_regs_mc
  import btc_miner_pkg::*;
#(
  parameter int NUM_CORES  = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        wbRst_n,
  input  logic [7:0]                  wbAddr,
  input  logic [3:0]                  wbSel,
  input  logic                        wbWe,
  input  logic [31:0]                 wbWData,
  input  logic                        wbCycle,
  input  logic                        wbStrobe,
  input  logic [2:0]                  wbCti,
  input  logic [1:0]                  wbBte,
  output logic [31:0]                 wbRData,
  output logic                        wbAck,
  output logic                        wbErr,
  output logic                        wbRty,
  output logic [32*HEADER_WORDS-1:0]  header,
  output logic [32*NUM_CORES-1:0]     nonce_start,
  output logic [NUM_CORES-1:0]        start,
  output logic                        config_use_nonce_in,
  output logic                        config_oneshot,
  output logic                        irq,
  input  logic [32*NUM_CORES-1:0]     nonce_a,
  input  logic [NUM_CORES-1:0]        done_a,
  input  logic [NUM_CORES-1:0]        nonce_found_a
);

  logic                 ack_q;
  logic [31:0]          rdata_q, rdata_d;
  logic                 use_nonce_in_q, oneshot_q, irq_en_q, irq_q, overflow_q;
  logic [NUM_CORES-1:0] core_en_q, start_q;
  logic [31:0]          header_q      [HEADER_WORDS];
  logic [31:0]          nonce_start_q [NUM_CORES];
  logic [31:0]          nonce_cap_q   [NUM_CORES];
  logic [NUM_CORES-1:0] done_x_q, done_s_q, done_d_q, done_lvl_q;
  logic [NUM_CORES-1:0] pending_q, pending_d, done_edge, grant_oh;

  logic                 access, wr_en, rd_en, is_hdr;
  logic [7:0]           addr_al;
  logic [4:0]           hdr_idx;
  logic                 ctrl_wr, start_pulse, clr_ovf, flush, pop;
  logic                 push, ovf_set;
  logic [2:0]           grant_id;
  logic [31:0]          grant_nonce;
  logic                 fifo_full, fifo_empty;
  logic [CNT_W-1:0]     fifo_count;
  logic [ENTRY_W-1:0]   fifo_head;
  logic                 unused_wb;

  assign unused_wb = ^{wbCti, wbBte, wbAddr[1:0]};

  // Access phase is the first strobe cycle; the registered ack closes it.
  assign access  = wbCycle & wbStrobe & ~ack_q;
  assign wr_en   = access & wbWe;
  assign rd_en   = access & ~wbWe;
  assign addr_al = {wbAddr[7:2], 2'b00};
  assign is_hdr  = (addr_al >= ADDR_HDR_FIRST) && (addr_al <= ADDR_HDR_LAST);
  assign hdr_idx = 5'(wbAddr[7:2] - 6'd1);

  assign ctrl_wr     = wr_en && (addr_al == ADDR_CONTROL) && wbSel[0];
  assign start_pulse = ctrl_wr & wbWData[CTRL_START_BIT];
  assign clr_ovf     = ctrl_wr & wbWData[CTRL_CLR_OVF_BIT];
  assign flush       = ctrl_wr & wbWData[CTRL_FLUSH_BIT];
  assign pop         = rd_en && (addr_al == ADDR_RESULT_NONCE);

  assign done_edge = done_s_q ^ done_d_q;

  always_comb begin
    push        = 1'b0;
    grant_oh    = '0;
    grant_id    = '0;
    grant_nonce = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        push        = 1'b1;
        grant_oh    = '0;
        grant_oh[i] = 1'b1;
        grant_id    = 3'(i);
        grant_nonce = nonce_cap_q[i];
      end
    end
    pending_d = (pending_q & ~grant_oh) | (done_edge & nonce_found_a);
    // A pending result that is still waiting when a new one lands is lost.
    ovf_set = (|(done_edge & nonce_found_a & pending_q & ~grant_oh))
            | (push & fifo_full & ~pop & ~flush);
  end

  always_comb begin
    rdata_d = '0;
    case (addr_al)
      ADDR_CONFIG: begin
        rdata_d[0]              = use_nonce_in_q;
        rdata_d[1]              = oneshot_q;
        rdata_d[8 +: NUM_CORES] = core_en_q;
      end
      ADDR_STATUS: begin
        rdata_d[NUM_CORES-1:0]  = done_lvl_q;
        rdata_d[8 +: CNT_W]     = fifo_count;
        rdata_d[STAT_EMPTY_BIT] = fifo_empty;
        rdata_d[STAT_OVF_BIT]   = overflow_q;
        rdata_d[STAT_IRQ_BIT]   = irq_q;
      end
      ADDR_RESULT_NONCE: if (!fifo_empty) rdata_d = fifo_head[31:0];
      ADDR_RESULT_INFO: if (!fifo_empty) begin
        rdata_d[31]  = 1'b1;
        rdata_d[2:0] = fifo_head[34:32];
      end
      ADDR_IRQ_EN: rdata_d[0] = irq_en_q;
      default: if (is_hdr) rdata_d = header_q[hdr_idx];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!wbRst_n) begin
      ack_q          <= 1'b0;
      rdata_q        <= '0;
      use_nonce_in_q <= 1'b0;
      oneshot_q      <= 1'b0;
      irq_en_q       <= 1'b0;
      irq_q          <= 1'b0;
      overflow_q     <= 1'b0;
      core_en_q      <= '0;
      start_q        <= '0;
      done_x_q       <= '0;
      done_s_q       <= '0;
      done_d_q       <= '0;
      done_lvl_q     <= '0;
      pending_q      <= '0;
      for (int k = 0; k < HEADER_WORDS; k++) header_q[k] <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        nonce_start_q[i] <= nonce_offset(i, NUM_CORES);
        nonce_cap_q[i]   <= '0;
      end
    end else begin
      ack_q <= wbCycle & wbStrobe & ~ack_q;
      if (rd_en) rdata_q <= rdata_d;
      if (wr_en) begin
        if (addr_al == ADDR_CONFIG) begin
          if (wbSel[0]) begin
            use_nonce_in_q <= wbWData[0];
            oneshot_q      <= wbWData[1];
          end
          if (wbSel[1]) core_en_q <= wbWData[8 +: NUM_CORES];
        end
        if ((addr_al == ADDR_IRQ_EN) && wbSel[0]) irq_en_q <= wbWData[0];
        if (is_hdr) begin
          for (int b = 0; b < 4; b++)
            if (wbSel[b]) header_q[hdr_idx][8*b +: 8] <= wbWData[8*b +: 8];
        end
      end
      if (start_pulse) start_q <= start_q ^ core_en_q;
      irq_q      <= irq_en_q & ~fifo_empty;
      overflow_q <= ovf_set | (overflow_q & ~clr_ovf);
      done_x_q   <= done_a;
      done_s_q   <= done_x_q;
      done_d_q   <= done_s_q;
      pending_q  <= pending_d;
      for (int i = 0; i < NUM_CORES; i++) begin
        if (done_edge[i]) begin
          done_lvl_q[i]  <= done_s_q[i];
          nonce_cap_q[i] <= nonce_a[32*i +: 32];
        end
        nonce_start_q[i] <= header_q[NONCE_IN_WORD] + nonce_offset(i, NUM_CORES);
      end
    end
  end

  btc_result_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (wbRst_n),
    .push_i  (push),
    .data_i  ({grant_id, grant_nonce}),
    .pop_i   (pop),
    .flush_i (flush),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .head_o  (fifo_head)
  );

  always_comb begin
    for (int k = 0; k < HEADER_WORDS; k++) header[32*k +: 32] = header_q[k];
    for (int i = 0; i < NUM_CORES; i++) nonce_start[32*i +: 32] = nonce_start_q[i];
  end

  assign wbRData             = rdata_q;
  assign wbAck               = ack_q;
  assign wbErr               = 1'b0;
  assign wbRty               = 1'b0;
  assign start               = start_q;
  assign config_use_nonce_in = use_nonce_in_q;
  assign config_oneshot      = oneshot_q;
  assign irq                 = irq_q;

endmodule

// File: tb/tb_btc_miner_regs_mc.sv
// Directed bench for btc_miner_regs_mc with a transaction-level register/queue
// model and a per-cycle output comparator active once the design has settled.
module tb_btc_miner_regs_mc;

  localparam int NC    = 4;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              wbRst_n;
  logic [7:0]        wbAddr;
  logic [3:0]        wbSel;
  logic              wbWe, wbCycle, wbStrobe;
  logic [31:0]       wbWData, wbRData;
  logic [2:0]        wbCti;
  logic [1:0]        wbBte;
  logic              wbAck, wbErr, wbRty;
  logic [639:0]      header;
  logic [32*NC-1:0]  nonce_start, nonce_a;
  logic [NC-1:0]     start, done_a, nonce_found_a;
  logic              config_use_nonce_in, config_oneshot, irq;

  always #5 clk = ~clk;

  btc_miner_regs_mc #(.NUM_CORES(NC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .wbRst_n(wbRst_n), .wbAddr(wbAddr), .wbSel(wbSel), .wbWe(wbWe),
    .wbWData(wbWData), .wbCycle(wbCycle), .wbStrobe(wbStrobe), .wbCti(wbCti),
    .wbBte(wbBte), .wbRData(wbRData), .wbAck(wbAck), .wbErr(wbErr), .wbRty(wbRty),
    .header(header), .nonce_start(nonce_start), .start(start),
    .config_use_nonce_in(config_use_nonce_in), .config_oneshot(config_oneshot),
    .irq(irq), .nonce_a(nonce_a), .done_a(done_a), .nonce_found_a(nonce_found_a)
  );

  int vec = 0, miss = 0;
  int cyc = 0, cyc_evt = 0;
  bit chk_on = 0;

  // Model state: what software should observe once everything has settled.
  logic [31:0]   m_hdr [20];
  logic          m_use, m_one, m_irq_en, m_ovf;
  logic [NC-1:0] m_en, m_start, m_lvl;
  logic [34:0]   m_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s = '0;
    s[NC-1:0] = m_lvl;
    s[8 +: CW] = CW'(m_q.size());
    s[16] = (m_q.size() == 0);
    s[17] = m_ovf;
    s[18] = m_irq_en && (m_q.size() != 0);
    return s;
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] a);
    logic [34:0] e;
    case (a)
      8'h00: return {16'b0, 8'(m_en), 6'b0, m_one, m_use};
      8'h58: return m_status();
      8'h5C: begin
        if (m_q.size() == 0) return 32'h0;
        e = m_q.pop_front();
        return e[31:0];
      end
      8'h60: begin
        if (m_q.size() == 0) return 32'h0;
        e = m_q[0];
        return {1'b1, 28'b0, e[34:32]};
      end
      8'h64: return {31'b0, m_irq_en};
      default: begin
        if (a >= 8'h04 && a <= 8'h50 && a[1:0] == 2'b00) return m_hdr[int'(a >> 2) - 1];
        return 32'h0;
      end
    endcase
  endfunction

  function automatic void m_write(input logic [7:0] a, input logic [3:0] sel, input logic [31:0] d);
    if (a == 8'h00) begin
      if (sel[0]) begin m_use = d[0]; m_one = d[1]; end
      if (sel[1]) m_en = d[8 +: NC];
    end else if (a >= 8'h04 && a <= 8'h50 && a[1:0] == 2'b00) begin
      for (int b = 0; b < 4; b++)
        if (sel[b]) m_hdr[int'(a >> 2) - 1][8*b +: 8] = d[8*b +: 8];
    end else if (a == 8'h54 && sel[0]) begin
      if (d[0]) m_start = m_start ^ m_en;
      if (d[1]) m_ovf = 1'b0;
      if (d[2]) m_q.delete();
    end else if (a == 8'h64 && sel[0]) begin
      m_irq_en = d[0];
    end
  endfunction

  function automatic void m_result(input int core, input logic found, input logic [31:0] n);
    m_lvl[core] = ~m_lvl[core];
    if (found) begin
      if (m_q.size() == DEPTH) m_ovf = 1'b1;
      else m_q.push_back({3'(core), n});
    end
  endfunction

  task automatic wb_cycle(input logic we, input logic [7:0] a, input logic [3:0] sel,
                          input logic [31:0] d, output logic [31:0] rd);
    int n;
    cyc_evt = cyc;
    @(posedge clk); #1;
    wbCycle = 1; wbStrobe = 1; wbWe = we; wbAddr = a; wbSel = sel; wbWData = d;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!wbAck && n < 8);
    chk("ack_latency", 64'(n), 64'd1);
    rd = wbRData;
    wbCycle = 0; wbStrobe = 0; wbWe = 0;
    @(posedge clk); #1;
    chk("single_ack", wbAck, 0);
    cyc_evt = cyc;
  endtask

  task automatic wb_write(input logic [7:0] a, input logic [3:0] sel, input logic [31:0] d);
    logic [31:0] dummy;
    wb_cycle(1'b1, a, sel, d, dummy);
    m_write(a, sel, d);
  endtask

  task automatic wb_read(input string name, input logic [7:0] a, output logic [31:0] act);
    logic [31:0] exp;
    exp = m_read(a);
    wb_cycle(1'b0, a, 4'hF, 32'h0, act);
    chk(name, act, exp);
  endtask

  task automatic toggle(input logic [NC-1:0] mask, input logic [NC-1:0] fnd,
                        input logic [32*NC-1:0] nv, input int settle);
    @(posedge clk); #1;
    cyc_evt = cyc;
    for (int i = 0; i < NC; i++)
      if (mask[i]) begin
        nonce_a[32*i +: 32] = nv[32*i +: 32];
        nonce_found_a[i] = fnd[i];
      end
    done_a = done_a ^ mask;
    for (int i = 0; i < NC; i++)
      if (mask[i]) m_result(i, fnd[i], nv[32*i +: 32]);
    repeat (settle) @(posedge clk);
    #1;
    cyc_evt = cyc;
  endtask

  always @(negedge clk) begin
    if (chk_on && (cyc - cyc_evt) >= 6) begin
      chk("irq", irq, m_irq_en && (m_q.size() != 0));
      chk("start", start, m_start);
      chk("cfg_use", config_use_nonce_in, m_use);
      chk("cfg_oneshot", config_oneshot, m_one);
      chk("wb_err_rty", {wbErr, wbRty}, 2'b00);
      for (int k = 0; k < 20; k++)
        chk($sformatf("header_w%0d", k), header[32*k +: 32], m_hdr[k]);
      for (int i = 0; i < NC; i++)
        chk($sformatf("nonce_start%0d", i), nonce_start[32*i +: 32],
            m_hdr[19] + 32'(i) * 32'(64'h1_0000_0000 / NC));
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  logic [31:0]      act;
  logic [32*NC-1:0] nv;

  initial begin
    wbRst_n = 0; wbAddr = 0; wbSel = 0; wbWe = 0; wbWData = 0;
    wbCycle = 0; wbStrobe = 0; wbCti = 0; wbBte = 0;
    nonce_a = '0; done_a = '0; nonce_found_a = '0;
    for (int k = 0; k < 20; k++) m_hdr[k] = '0;
    m_use = 0; m_one = 0; m_irq_en = 0; m_ovf = 0;
    m_en = '0; m_start = '0; m_lvl = '0;

    repeat (3) @(posedge clk);
    #1;
    wbRst_n = 1;
    chk("rst_nonce_start1", nonce_start[63:32], 32'h4000_0000);
    chk("rst_nonce_start3", nonce_start[127:96], 32'hC000_0000);
    chk("rst_irq", irq, 0);
    chk("rst_start", start, 0);
    chk("rst_ack", wbAck, 0);
    chk("rst_rdata", wbRData, 0);
    chk_on = 1;
    cyc_evt = cyc;

    for (int a = 0; a <= 8'h6C; a += 4) begin
      wb_read("rst_read", 8'(a), act);
      chk($sformatf("rst_lit_%0h", a), act, (a == 8'h58) ? 32'h0001_0000 : 32'h0);
    end
    wb_read("unmapped_read", 8'hFC, act);

    // Header byte enables and nonce partitioning.
    wb_write(8'h04, 4'b0101, 32'h1234_5678);
    wb_read("version", 8'h04, act);
    chk("version_lit", act, 32'h0034_0078);
    chk("header_w0_lit", header[31:0], 32'h0034_0078);
    wb_write(8'h28, 4'b1110, 32'hAABB_CCDD);
    wb_read("merkle1", 8'h28, act);
    wb_write(8'h50, 4'hF, 32'h0000_0010);
    chk("nonce_start2_lit", nonce_start[95:64], 32'h8000_0010);
    wb_read("nonce_in", 8'h50, act);

    // Config and start toggles.
    wb_write(8'h00, 4'b0011, 32'h0000_0501);
    wb_read("config", 8'h00, act);
    chk("config_lit", act, 32'h0000_0501);
    wb_write(8'h54, 4'b0001, 32'h1);
    chk("start_lit1", start, 4'b0101);
    wb_write(8'h54, 4'b0001, 32'h1);
    chk("start_lit2", start, 4'b0000);
    wb_write(8'h00, 4'b0001, 32'h0000_FF02);
    wb_read("config_sel0", 8'h00, act);
    chk("config_sel0_lit", act, 32'h0000_0502);
    wb_write(8'h58, 4'hF, 32'hFFFF_FFFF);
    wb_write(8'h80, 4'hF, 32'hFFFF_FFFF);
    wb_read("status_ro", 8'h58, act);

    // Single result with interrupt timing.
    wb_write(8'h64, 4'b0001, 32'h1);
    @(posedge clk); #1;
    cyc_evt = cyc;
    nonce_a[95:64] = 32'hDEAD_BEEF;
    nonce_found_a[2] = 1'b1;
    done_a[2] = ~done_a[2];
    m_result(2, 1'b1, 32'hDEAD_BEEF);
    repeat (4) @(posedge clk);
    #1;
    chk("irq_before_n3", irq, 0);
    @(posedge clk); #1;
    chk("irq_at_n3", irq, 1);
    cyc_evt = cyc;
    wb_read("status_one", 8'h58, act);
    chk("status_one_lit", act, 32'h0004_0104);
    wb_read("info_one", 8'h60, act);
    chk("info_one_lit", act, 32'h8000_0002);
    wb_read("nonce_one", 8'h5C, act);
    chk("nonce_one_lit", act, 32'hDEAD_BEEF);
    wb_read("status_drained", 8'h58, act);
    chk("status_drained_lit", act, 32'h0001_0004);
    chk("irq_drained", irq, 0);

    // Simultaneous results: lowest core first.
    nv = '0;
    nv[31:0]   = 32'h1111_0000;
    nv[127:96] = 32'h3333_0000;
    toggle(4'b1001, 4'b1001, nv, 10);
    wb_read("info_c0", 8'h60, act);
    chk("info_c0_lit", act, 32'h8000_0000);
    wb_read("nonce_c0", 8'h5C, act);
    chk("nonce_c0_lit", act, 32'h1111_0000);
    wb_read("info_c3", 8'h60, act);
    chk("info_c3_lit", act, 32'h8000_0003);
    wb_read("nonce_c3", 8'h5C, act);
    chk("nonce_c3_lit", act, 32'h3333_0000);
    nv = '0;
    nv[63:32] = 32'h0000_5555;
    toggle(4'b0010, 4'b0000, nv, 10);
    wb_read("status_nofound", 8'h58, act);
    chk("status_nofound_lit", act, 32'h0001_000F);

    // Overflow the FIFO by one entry.
    for (int k = 0; k <= DEPTH; k++) begin
      nv = '0;
      nv[32*(k % NC) +: 32] = 32'hA000_0000 + 32'(k);
      toggle(NC'(1 << (k % NC)), NC'(1 << (k % NC)), nv, 8);
    end
    wb_read("status_full", 8'h58, act);
    chk("status_full_lit", act, 32'h0006_080E);
    wb_read("info_old0", 8'h60, act);
    chk("info_old0_lit", act, 32'h8000_0000);
    wb_read("nonce_old0", 8'h5C, act);
    chk("nonce_old0_lit", act, 32'hA000_0000);
    wb_read("info_old1", 8'h60, act);
    chk("info_old1_lit", act, 32'h8000_0001);
    wb_read("nonce_old1", 8'h5C, act);
    chk("nonce_old1_lit", act, 32'hA000_0001);
    wb_write(8'h54, 4'b0001, 32'h2);
    wb_read("status_clr_ovf", 8'h58, act);
    chk("status_clr_ovf_lit", act, 32'h0004_060E);
    wb_write(8'h54, 4'b0001, 32'h4);
    wb_read("status_flush", 8'h58, act);
    chk("status_flush_lit", act, 32'h0001_000E);
    wb_read("nonce_empty", 8'h5C, act);
    chk("nonce_empty_lit", act, 32'h0);
    wb_read("info_empty", 8'h60, act);
    chk("info_empty_lit", act, 32'h0);

    repeat (10) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
